// File: rtl/pdu_pkg.sv
// rtl/pdu_pkg.sv - shared halt-cause codes, FSM states and sizing helper for the run-control path
package pdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [1:0] HC_NONE   = 2'd0;
  localparam logic [1:0] HC_BP     = 2'd1;
  localparam logic [1:0] HC_STOP   = 2'd2;
  localparam logic [1:0] HC_BUDGET = 2'd3;

  // Index width with a floor of one bit so a single-breakpoint build still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// rtl/btn_pulse.sv - button debouncer producing a one-cycle pulse on each accepted press
module btn_pulse #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;

  // The counter only advances while raw disagrees with the stable value, so any
  // bounce back to the stable level restarts the qualification window.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (btn_raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d    = '0;
      stable_d = btn_raw;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    pulse_d = stable_d && !stable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/pdu_run_ctrl.sv
// rtl/pdu_run_ctrl.sv - PDU run/stop controller with breakpoints, single-step and cycle budget
module pdu_run_ctrl
  import pdu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int N_BP            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_run,
  input  logic                    btn_stop,
  input  logic                    step_mode,
  input  logic                    bp_we,
  input  logic [idx_w(N_BP)-1:0]  bp_idx,
  input  logic [XLEN-1:0]         bp_wdata,
  input  logic                    bp_wvalid,
  input  logic [CNT_W-1:0]        run_budget,
  input  logic                    clr_cnt,
  input  logic [XLEN-1:0]         chk_if_pc,
  output logic                    cpu_en,
  output logic                    cpu_stop,
  output logic [1:0]              halt_cause,
  output logic [idx_w(N_BP)-1:0]  hit_idx,
  output logic [CNT_W-1:0]        run_cycles
);

  localparam int IW = idx_w(N_BP);

  logic run_p;
  logic stop_p;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_run),
    .pulse   (run_p)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_stop),
    .pulse   (stop_p)
  );

  state_e            state_q, state_d;
  logic              cpu_en_q, cpu_en_d;
  logic [1:0]        cause_q, cause_d;
  logic [IW-1:0]     hit_idx_q, hit_idx_d;
  logic              skip_q, skip_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
  logic [XLEN-1:0]   bp_addr_q [N_BP];
  logic [XLEN-1:0]   bp_addr_d [N_BP];
  logic [N_BP-1:0]   bp_valid_q, bp_valid_d;

  logic [N_BP-1:0]   match;
  logic              hit;
  logic [IW-1:0]     hit_lo;
  logic              budget_hit;

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    match  = '0;
    hit_lo = '0;
    for (int i = 0; i < N_BP; i++) begin
      match[i] = bp_valid_q[i] && (chk_if_pc == bp_addr_q[i]);
    end
    for (int i = N_BP - 1; i >= 0; i--) begin
      if (match[i]) hit_lo = IW'(i);
    end
    hit        = (|match) && !skip_q;
    budget_hit = (run_budget != '0) && (bcnt_q == run_budget - CNT_W'(1));
  end

  always_comb begin
    bp_addr_d  = bp_addr_q;
    bp_valid_d = bp_valid_q;
    if (bp_we && (32'(bp_idx) < 32'(N_BP))) begin
      bp_addr_d[bp_idx]  = bp_wdata;
      bp_valid_d[bp_idx] = bp_wvalid;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    hit_idx_d = hit_idx_q;
    skip_d    = skip_q;
    bcnt_d    = bcnt_q;
    case (state_q)
      IDLE, HALT: begin
        if (run_p) begin
          state_d   = step_mode ? STEP : RUN;
          cause_d   = HC_NONE;
          hit_idx_d = '0;
          bcnt_d    = '0;
          skip_d    = 1'b1;
        end
      end
      STEP: begin
        state_d = HALT;
        cause_d = HC_NONE;
        skip_d  = 1'b0;
      end
      RUN: begin
        skip_d = 1'b0;
        bcnt_d = bcnt_q + CNT_W'(1);
        if (stop_p) begin
          state_d = HALT;
          cause_d = HC_STOP;
        end else if (hit) begin
          state_d   = HALT;
          cause_d   = HC_BP;
          hit_idx_d = hit_lo;
        end else if (budget_hit) begin
          state_d = HALT;
          cause_d = HC_BUDGET;
        end
      end
      default: state_d = IDLE;
    endcase
    cpu_en_d = (state_d == RUN) || (state_d == STEP);
  end

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (clr_cnt) begin
      run_cycles_d = '0;
    end else if (cpu_en_q && (run_cycles_q != '1)) begin
      run_cycles_d = run_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cpu_en_q     <= 1'b0;
      cause_q      <= HC_NONE;
      hit_idx_q    <= '0;
      skip_q       <= 1'b0;
      bcnt_q       <= '0;
      run_cycles_q <= '0;
      bp_valid_q   <= '0;
      for (int i = 0; i < N_BP; i++) bp_addr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cpu_en_q     <= cpu_en_d;
      cause_q      <= cause_d;
      hit_idx_q    <= hit_idx_d;
      skip_q       <= skip_d;
      bcnt_q       <= bcnt_d;
      run_cycles_q <= run_cycles_d;
      bp_valid_q   <= bp_valid_d;
      for (int i = 0; i < N_BP; i++) bp_addr_q[i] <= bp_addr_d[i];
    end
  end

  assign cpu_en     = cpu_en_q;
  assign cpu_stop   = !cpu_en_q;
  assign halt_cause = cause_q;
  assign hit_idx    = hit_idx_q;
  assign run_cycles = run_cycles_q;

endmodule
